// File: rtl/cpu_cycle_sequencer.sv
// T-state / M-cycle sequencer with registered one-hot opcode field decode.
// Drives the per-X-group microcode blocks and consumes their OR-ed fetch request.
module cpu_cycle_sequencer (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Stall,
    input  logic       i_Fetch,
    input  logic [7:0] i_Data,
    input  logic [7:0] i_Flags,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic [3:0] o_X_Active,
    output logic       o_CB_Active,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic [3:0] o_P,
    output logic [1:0] o_Q,
    output logic [3:0] o_Conditions,
    output logic [7:0] o_Opcode,
    output logic       o_Overrun
);

    typedef enum logic [3:0] {
        T1 = 4'b0001,
        T2 = 4'b0010,
        T3 = 4'b0100,
        T4 = 4'b1000
    } step_e;

    step_e      step_q, step_d;
    logic [7:0] count_q, count_d;
    logic [7:0] opcode_q, opcode_d;
    logic       cb_q, cb_d;
    logic       overrun_q, overrun_d;
    logic [3:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] z_q, z_d;
    logic [3:0] p_q, p_d;
    logic [1:0] q_q, q_d;
    logic       latch;

    always_comb begin
        step_d    = step_q;
        count_d   = count_q;
        opcode_d  = opcode_q;
        cb_d      = cb_q;
        overrun_d = overrun_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        p_d       = p_q;
        q_d       = q_q;
        latch     = 1'b0;

        if (!i_Stall) begin
            unique case (step_q)
                T1:      step_d = T2;
                T2:      step_d = T3;
                T3:      step_d = T4;
                T4:      step_d = T1;
                default: step_d = T1;
            endcase
            if (step_q == T4) begin
                if (i_Fetch) begin
                    latch   = 1'b1;
                    count_d = 8'h01;
                end else if (count_q == 8'h80) begin
                    overrun_d = 1'b1;
                end else begin
                    count_d = count_q << 1;
                end
            end
        end

        // A CB byte is a prefix only when it is not itself a CB-page opcode.
        if (latch) begin
            opcode_d = i_Data;
            cb_d     = (opcode_q == 8'hCB) && !cb_q;
            x_d      = cb_d ? 4'b0000 : (4'b0001 << i_Data[7:6]);
            y_d      = 8'h01 << i_Data[5:3];
            z_d      = 8'h01 << i_Data[2:0];
            p_d      = 4'b0001 << i_Data[5:4];
            q_d      = 2'b01 << i_Data[3];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            step_q    <= T1;
            count_q   <= 8'h01;
            opcode_q  <= 8'h00;
            cb_q      <= 1'b0;
            overrun_q <= 1'b0;
            x_q       <= 4'b0001;
            y_q       <= 8'h01;
            z_q       <= 8'h01;
            p_q       <= 4'b0001;
            q_q       <= 2'b01;
        end else begin
            step_q    <= step_d;
            count_q   <= count_d;
            opcode_q  <= opcode_d;
            cb_q      <= cb_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            p_q       <= p_d;
            q_q       <= q_d;
        end
    end

    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_Opcode      = opcode_q;
    assign o_CB_Active   = cb_q;
    assign o_Overrun     = overrun_q;
    assign o_X_Active    = x_q;
    assign o_Y           = y_q;
    assign o_Z           = z_q;
    assign o_P           = p_q;
    assign o_Q           = q_q;

    assign o_Conditions = {i_Flags[4], ~i_Flags[4], i_Flags[7], ~i_Flags[7]};

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Scoreboard bench for cpu_cycle_sequencer: a reference model pushes expected
// outputs per clock, a monitor pops and compares after each rising edge.
module tb_cpu_cycle_sequencer;

    logic       clk = 1'b1;
    logic       rst_n, stall, fetch;
    logic [7:0] data, flags;

    logic [3:0] step, x, p, cond;
    logic [7:0] count, y, z, opcode;
    logic [1:0] q;
    logic       cb, ovr;

    cpu_cycle_sequencer dut (
        .i_Clk        (clk),
        .i_Reset_n    (rst_n),
        .i_Stall      (stall),
        .i_Fetch      (fetch),
        .i_Data       (data),
        .i_Flags      (flags),
        .o_Cycle_Step (step),
        .o_Cycle_Count(count),
        .o_X_Active   (x),
        .o_CB_Active  (cb),
        .o_Y          (y),
        .o_Z          (z),
        .o_P          (p),
        .o_Q          (q),
        .o_Conditions (cond),
        .o_Opcode     (opcode),
        .o_Overrun    (ovr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] step;
        logic [7:0] count;
        logic [3:0] x;
        logic       cb;
        logic [7:0] y;
        logic [7:0] z;
        logic [3:0] p;
        logic [1:0] q;
        logic [3:0] cond;
        logic [7:0] op;
        logic       ovr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    // Reference model: T-state and M-cycle kept as plain integers.
    int       m_t = 0;
    int       m_m = 0;
    bit [7:0] m_op = 8'h00;
    bit       m_cb = 1'b0;
    bit       m_ovr = 1'b0;

    function automatic exp_t expected(input bit [7:0] f);
        exp_t e;
        e.step  = 4'(1 << m_t);
        e.count = 8'(1 << m_m);
        e.x     = m_cb ? 4'd0 : 4'(1 << (m_op / 64));
        e.cb    = m_cb;
        e.y     = 8'(1 << ((m_op / 8) % 8));
        e.z     = 8'(1 << (m_op % 8));
        e.p     = 4'(1 << ((m_op / 16) % 4));
        e.q     = 2'(1 << ((m_op / 8) % 2));
        e.cond  = {f[4], !f[4], f[7], !f[7]};
        e.op    = m_op;
        e.ovr   = m_ovr;
        return e;
    endfunction

    task automatic tick(input bit r, input bit s, input bit fe,
                        input bit [7:0] d, input bit [7:0] f);
        @(negedge clk);
        rst_n = r;
        stall = s;
        fetch = fe;
        data  = d;
        flags = f;
        if (!r) begin
            m_t = 0; m_m = 0; m_op = 8'h00; m_cb = 0; m_ovr = 0;
        end else if (!s) begin
            if (m_t == 3) begin
                if (fe) begin
                    m_cb = (m_op == 8'hCB) && !m_cb;
                    m_op = d;
                    m_m  = 0;
                end else if (m_m == 7) begin
                    m_ovr = 1;
                end else begin
                    m_m = m_m + 1;
                end
            end
            m_t = (m_t + 1) % 4;
        end
        sb.push_back(expected(f));
    endtask

    // Runs nm M-cycles from T1, fetching d at the final T4; fetch is random elsewhere
    // except at earlier T4s, where it must stay low.
    task automatic op(input bit [7:0] d, input int nm, input bit [7:0] f);
        for (int c = 0; c < 4 * nm; c++) begin
            bit fe;
            if (c == 4 * nm - 1) fe = 1;
            else if (m_t == 3) fe = 0;
            else fe = 1'($urandom % 2);
            tick(1, 0, fe, d, f);
        end
    endtask

    initial begin : monitor
        exp_t a;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) begin
                if (!done) begin
                    errors++;
                    $display("FAIL sb_empty at %0t", $time);
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                a = '{step, count, x, cb, y, z, p, q, cond, opcode, ovr};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs at %0t: got %h want %h (step cnt x cb y z p q cond op ovr)",
                             $time, a, e);
                end
            end
        end
    end

    initial begin : driver
        tick(0, 0, 0, 8'h00, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        op(8'h20, 1, 8'h80);
        op(8'h01, 1, 8'h10);
        op(8'h00, 3, 8'h90);
        op(8'hCB, 1, 8'h00);
        op(8'h37, 1, 8'h00);
        op(8'h00, 1, 8'h00);
        op(8'hCB, 1, 8'h80);
        op(8'hCB, 1, 8'h80);
        op(8'hCB, 1, 8'h80);
        op(8'h00, 1, 8'h80);
        // Mid-instruction reset: M3/T3.
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 8'h55, 8'h00);
        tick(0, 0, 1, 8'h55, 8'h00);
        tick(0, 0, 1, 8'h55, 8'h00);
        // Stall at T2, then stall at T4 with fetch high.
        tick(1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 8'hAA, 8'h00);
        tick(1, 0, 0, 8'h00, 8'h00);
        tick(1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) tick(1, 1, 1, 8'hAA, 8'h00);
        tick(1, 0, 1, 8'h11, 8'h00);
        // Overrun: ten M-cycles without fetch.
        for (int i = 0; i < 40; i++) tick(1, 0, 0, 8'hFF, 8'h10);
        op(8'h22, 1, 8'h00);
        op(8'h3C, 2, 8'h00);
        tick(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            bit [7:0] d;
            int mode;
            mode = (i / 250) % 3;
            d = ($urandom % 4 == 0) ? 8'hCB : 8'($urandom);
            tick(($urandom % 300) != 0,
                 ($urandom % 6) == 0,
                 mode == 0 ? ($urandom % 3 != 0) :
                 mode == 1 ? ($urandom % 8 == 0) : 1'b1,
                 d, 8'($urandom));
        end
        done = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover %0d entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
